// File: rtl/asmd_scaler_pkg.sv
// Shared types for the ASMD scaler: control FSM states and the result mode chosen in EVAL.
package asmd_scaler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        POS  = 2'd0,
        NEG  = 2'd1,
        ZERO = 2'd2
    } mode_t;

endpackage

// File: rtl/asmd_scaler_dp.sv
// Datapath for the ASMD scaler: operand, result and count registers plus the
// per-step saturating double / truncating halve, all sequenced by strobes from the top.
module asmd_scaler_dp
    import asmd_scaler_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             load,
    input  logic             eval,
    input  logic             step,
    input  logic [WIDTH-1:0] data_ar,
    input  logic [WIDTH-1:0] data_br,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] cr,
    output logic             ovf,
    output logic             ar_gt_0,
    output logic             ar_lt_0,
    output logic             cnt_is_zero,
    output logic             cnt_is_one
);

    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] ar_q;
    logic signed [WIDTH-1:0] br_q;
    logic signed [WIDTH-1:0] cr_q;
    logic [SHW-1:0]          cnt_q;
    mode_t                   mode_q;
    logic                    ovf_q;

    logic signed [WIDTH-1:0] step_cr;
    logic signed [WIDTH-1:0] bias_sum;
    logic                    step_ovf;

    assign ar_lt_0     = ar_q[WIDTH-1];
    assign ar_gt_0     = !ar_q[WIDTH-1] && (ar_q != '0);
    assign cnt_is_zero = (cnt_q == '0);
    assign cnt_is_one  = (cnt_q == SHW'(1));
    assign cr          = cr_q;
    assign ovf         = ovf_q;

    // Doubling overflows exactly when the two top bits differ. Halving adds 1 to
    // negative values before the arithmetic shift so the result truncates toward zero.
    always_comb begin
        step_cr  = cr_q;
        step_ovf = 1'b0;
        bias_sum = cr_q + {{(WIDTH-1){1'b0}}, cr_q[WIDTH-1]};
        case (mode_q)
            POS: begin
                if (cr_q[WIDTH-1] != cr_q[WIDTH-2]) begin
                    step_cr  = cr_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
                    step_ovf = 1'b1;
                end else begin
                    step_cr = cr_q <<< 1;
                end
            end
            NEG:     step_cr = bias_sum >>> 1;
            default: step_cr = cr_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ar_q   <= '0;
            br_q   <= '0;
            cr_q   <= '0;
            cnt_q  <= '0;
            mode_q <= ZERO;
            ovf_q  <= 1'b0;
        end else if (load) begin
            ar_q  <= data_ar;
            br_q  <= data_br;
            cnt_q <= shamt;
            cr_q  <= '0;
            ovf_q <= 1'b0;
        end else if (eval) begin
            if (ar_gt_0) begin
                mode_q <= POS;
                cr_q   <= br_q;
            end else if (ar_lt_0) begin
                mode_q <= NEG;
                cr_q   <= ar_q;
            end else begin
                mode_q <= ZERO;
                cr_q   <= '0;
            end
        end else if (step) begin
            cr_q  <= step_cr;
            cnt_q <= cnt_q - 1'b1;
            if (step_ovf) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/asmd_scaler.sv
// ASMD scaler top: control FSM (IDLE/EVAL/SHIFT/DONE) driving the datapath via
// load/eval/step strobes; done is a registered one-cycle completion pulse.
module asmd_scaler
    import asmd_scaler_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic [WIDTH-1:0] data_ar,
    input  logic [WIDTH-1:0] data_br,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] cr,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    // Handshake: start is accepted only on an edge where busy is low; busy stays
    // high from the following cycle until done has pulsed; cr/ovf are valid with done
    // and hold until the next accepted start.
    state_t state_q;
    state_t state_d;
    logic   done_q;
    logic   load;
    logic   eval;
    logic   step;
    logic   ar_gt_0;
    logic   ar_lt_0;
    logic   cnt_is_zero;
    logic   cnt_is_one;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        eval    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                eval = 1'b1;
                if ((!ar_gt_0 && !ar_lt_0) || cnt_is_zero) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt_is_one) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    asmd_scaler_dp #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_dp (
        .clk        (clk),
        .reset_b    (reset_b),
        .load       (load),
        .eval       (eval),
        .step       (step),
        .data_ar    (data_ar),
        .data_br    (data_br),
        .shamt      (shamt),
        .cr         (cr),
        .ovf        (ovf),
        .ar_gt_0    (ar_gt_0),
        .ar_lt_0    (ar_lt_0),
        .cnt_is_zero(cnt_is_zero),
        .cnt_is_one (cnt_is_one)
    );

endmodule

// File: tb/tb_asmd_scaler.sv
// Bench for asmd_scaler: scoreboard of {ovf, cr} and latency from a small integer
// model, directed corner cases, start-while-busy, mid-shift reset, and random ops.
module tb_asmd_scaler;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;

    logic             clk;
    logic             reset_b;
    logic             start;
    logic [WIDTH-1:0] data_ar;
    logic [WIDTH-1:0] data_br;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] cr;
    logic             busy;
    logic             done;
    logic             ovf;

    int tests_run;
    int tests_failed;

    logic [WIDTH:0] exp_q[$];
    int             lat_q[$];

    asmd_scaler #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) dut (
        .clk    (clk),
        .reset_b(reset_b),
        .start  (start),
        .data_ar(data_ar),
        .data_br(data_br),
        .shamt  (shamt),
        .cr     (cr),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic, clamped each doubling step.
    task automatic model_push(input logic [WIDTH-1:0] ar, input logic [WIDTH-1:0] br,
                              input logic [SHW-1:0] n);
        int v;
        bit o;
        int a;
        a = $signed(ar);
        o = 1'b0;
        if (a > 0) v = $signed(br);
        else if (a < 0) v = a;
        else v = 0;
        if (a != 0) begin
            for (int i = 0; i < int'(n); i++) begin
                if (a > 0) begin
                    v = v * 2;
                    if (v > 32767) begin v = 32767; o = 1'b1; end
                    if (v < -32768) begin v = -32768; o = 1'b1; end
                end else begin
                    v = v / 2;
                end
            end
        end
        exp_q.push_back({o, v[WIDTH-1:0]});
        lat_q.push_back((a == 0 || n == 0) ? 1 : int'(n) + 1);
    endtask

    // Driver + monitor for one operation; poke re-pulses start with other operands mid-run.
    task automatic run_op(input logic [WIDTH-1:0] ar, input logic [WIDTH-1:0] br,
                          input logic [SHW-1:0] n, input bit poke);
        int lat;
        bit got;
        logic [WIDTH:0] e;
        int el;
        model_push(ar, br, n);
        @(negedge clk);
        data_ar = ar;
        data_br = br;
        shamt   = n;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (poke && k == 2) begin
                start   = 1'b1;
                data_ar = 16'h0001;
                data_br = 16'h7777;
                shamt   = 4'd1;
            end
            @(posedge clk);
            #1;
            if (poke && k == 2) start = 1'b0;
            if (done) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("cr", {16'd0, cr}, {16'd0, e[WIDTH-1:0]});
            check("ovf", {31'd0, ovf}, {31'd0, e[WIDTH]});
            check("latency", lat, el);
            @(posedge clk);
            #1;
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("idle_after_done", {31'd0, busy}, 32'd0);
            check("cr_hold", {16'd0, cr}, {16'd0, e[WIDTH-1:0]});
            check("ovf_hold", {31'd0, ovf}, {31'd0, e[WIDTH]});
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start        = 1'b0;
        data_ar      = '0;
        data_br      = '0;
        shamt        = '0;
        reset_b      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cr", {16'd0, cr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        reset_b = 1'b1;

        // Directed cases
        run_op(16'd5,    16'h0003, 4'd3, 1'b0);
        run_op(16'd5,    16'h4000, 4'd2, 1'b0);
        run_op(16'd5,    16'hC001, 4'd2, 1'b0);
        run_op(16'hFF9C, 16'h0000, 4'd3, 1'b0);
        run_op(16'hFFFF, 16'h0000, 4'd2, 1'b0);
        run_op(16'h0000, 16'h1234, 4'd7, 1'b0);
        run_op(16'h0001, 16'h1234, 4'd0, 1'b0);
        run_op(16'hFFFD, 16'h0000, 4'd1, 1'b0);
        run_op(16'h8000, 16'h0000, 4'd15, 1'b0);
        run_op(16'h7FFF, 16'h8000, 4'd1, 1'b0);
        run_op(16'd5,    16'h0003, 4'd6, 1'b1);

        // Reset mid-SHIFT, asserted away from any clock edge
        model_push(16'd5, 16'h0001, 4'd10);
        @(negedge clk);
        data_ar = 16'd5;
        data_br = 16'h0001;
        shamt   = 4'd10;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("mid_shift_cr_nonzero", {31'd0, (cr != '0)}, 32'd1);
        reset_b = 1'b0;
        #1;
        check("arst_cr", {16'd0, cr}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_ovf", {31'd0, ovf}, 32'd0);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        @(posedge clk);
        #2;
        reset_b = 1'b1;
        run_op(16'd5, 16'h0003, 4'd3, 1'b0);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   4'($urandom_range(0, 15)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
